mem_access: RTL and testbench
=============================

# mem_access

Memory-access stage of the multi-cycle core, downstream of the control unit's execute stage. It is started by a one-cycle pulse once the ALU address is valid. It performs byte, halfword or word loads and stores against the shared 32-bit, word-wide RAM, and returns sign- or zero-extended load data for write back. Sub-word stores use read-modify-write because the RAM has no byte enables.

## Interface
- RD_LAT, 1: RAM read latency in cycles, legal range 1..4; `data_i` is sampled RD_LAT edges after the edge that registers `addr_o`.
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- start_i  in  1  one-cycle request pulse; honoured only in IDLE
- op_i  in  2  01 load, 10 store, 00/11 no memory op
- funct3_i  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only)
- addr_i  in  32  byte address from the ALU
- wdata_i  in  32  store data (rs2)
- busy_o  out  1  access in progress
- done_o  out  1  one-cycle completion pulse
- fault_o  out  1  valid with done_o; illegal size or misaligned access
- rd_data_o  out  32  extended load result; held until the next load completes
- we_o  out  1  RAM write enable
- addr_o  out  32  word-aligned RAM address ({addr_i[31:2],2'b00}); 0 when idle
- data_i  in  32  RAM read data
- data_o  out  32  RAM write data; 0 when idle

## Operation
- Reset values: all outputs 0; state IDLE.
- FSM states: IDLE, READ (waits RD_LAT cycles), WRITE (one cycle with we_o=1).
- Transitions on the start edge E0:
  - No memory op (op_i 00/11): no bus activity; done_o=1 at E0, fault_o=0.
  - Illegal funct3 (loads: 011, 110, 111; stores: anything except 000/001/010): no bus activity; done_o=1, fault_o=1 at E0.
  - Load, or store with funct3 000/001: register addr_o, we_o=0; go to READ.
  - SW: register addr_o, data_o=wdata_i, we_o=1; go to WRITE.
- READ, on edge E0+RD_LAT:
  - Load: rd_data_o = extended lane; done_o=1; back to IDLE.
  - Sub-word store: data_o = data_i with the target lane replaced by wdata_i[7:0] or wdata_i[15:0]; we_o=1; go to WRITE.
- WRITE: on the next edge, we_o=0, addr_o=0, data_o=0, done_o=1; back to IDLE.
- Byte lanes are little-endian: byte k = data[8k+7:8k] with k=addr_i[1:0]; halfword j=addr_i[1] is data[16j+15:16j].
- Extension: B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through unchanged.
- addr_i, wdata_i, op_i and funct3_i are latched at E0. Later changes have no effect.
- start_i is ignored while busy_o=1.
- The top level ORs addr_o/data_o/we_o with the control unit's RAM drive. This block drives zeros whenever idle.

## Timing
- busy_o rises at E0 for any access that goes to READ or WRITE, and falls with the done_o edge.
- Latency from start to done_o visible:
  - No-op or fault: 1 cycle.
  - LW/LB/LH/LBU/LHU: RD_LAT+1 cycles.
  - SW: 2 cycles.
  - SB/SH: RD_LAT+2 cycles.
- Back-to-back: start_i is accepted in the same cycle done_o is high, because the state is already IDLE.
- Reset mid-access: at the reset edge, we_o=0 (any pending write is aborted), the state returns to IDLE, and done_o is not asserted. rd_data_o resets to 0.
- A fault never changes rd_data_o and never asserts we_o.

## Configuration
- MEM_ACCESS_MISALIGN_TRAP_EN defined:
  - H/HU/SH with addr_i[0]=1 complete at E0 with done_o=1, fault_o=1, and no bus activity.
  - W/SW with addr_i[1:0]≠0 do the same.
- Not defined:
  - No misalignment fault.
  - Halfword accesses use lane addr_i[1] and ignore addr_i[0].
  - Word accesses ignore addr_i[1:0].

## Test plan
- RAM[0x100]=0x8899AABB, LB addr 0x101, RD_LAT=1 -> done_o 2 cycles after start, rd_data_o=0xFFFFFFAA; LBU gives 0x000000AA.
- RAM[0x100]=0x11223344, SH addr 0x102, wdata 0xCAFE -> read, then exactly one we_o cycle with data_o=0xCAFE3344, done_o at RD_LAT+2.
- SW addr 0x200, wdata 0xDEADBEEF -> we_o high exactly 1 cycle at addr 0x200, done_o 2 cycles after start; a second start_i pulsed while busy_o=1 produces no extra access.
- LW addr 0x102: with the macro -> fault_o=1, done_o at 1 cycle, no bus access; without the macro -> reads 0x100 with no fault.
- Reset asserted during the WRITE cycle of SB -> we_o=0 on the following cycle, no done_o, all outputs 0.
- op_i=00 and illegal funct3=011 load -> done_o after 1 cycle with fault_o=0 and fault_o=1 respectively; addr_o stays 0 in both cases.

Source files
------------

// File: rtl/mem_access.sv
// Memory-access stage: byte/halfword/word loads and stores on a word-wide RAM,
// sub-word stores via read-modify-write. Optional MEM_ACCESS_MISALIGN_TRAP_EN faults misaligned accesses.
module mem_access #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        fault_o,
  output logic [31:0] rd_data_o,
  output logic        we_o,
  output logic [31:0] addr_o,
  input  logic [31:0] data_i,
  output logic [31:0] data_o
);

  localparam int unsigned CNT_W = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_f3;
  logic [1:0]       r_lane;
  logic             r_store;
  logic [15:0]      r_wdata;
  logic             r_busy;
  logic             r_done;
  logic             r_fault;
  logic [31:0]      r_rd;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_data;

  logic [1:0]       w_state;
  logic [CNT_W-1:0] w_cnt;
  logic [2:0]       w_f3;
  logic [1:0]       w_lane;
  logic             w_store;
  logic [15:0]      w_wdata;
  logic             w_busy;
  logic             w_done;
  logic             w_fault;
  logic [31:0]      w_rd;
  logic             w_we;
  logic [31:0]      w_addr;
  logic [31:0]      w_data;

  logic             w_is_load;
  logic             w_is_store;
  logic             w_legal;
  logic             w_misalign;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [31:0]      w_ext;
  logic [31:0]      w_merge;

  // Request decode on the incoming (not yet latched) command.
  always_comb begin
    w_is_load  = (op_i == OP_LOAD);
    w_is_store = (op_i == OP_STORE);
    w_legal    = 1'b0;
    if (w_is_load) begin
      case (funct3_i)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: w_legal = 1'b1;
        default:                        w_legal = 1'b0;
      endcase
    end else if (w_is_store) begin
      case (funct3_i)
        F3_B, F3_H, F3_W: w_legal = 1'b1;
        default:          w_legal = 1'b0;
      endcase
    end
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    w_misalign = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                 ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
`else
    w_misalign = 1'b0;
`endif
  end

  // Lane extraction / extension for loads and lane merge for sub-word stores.
  always_comb begin
    w_byte  = data_i[{r_lane, 3'b000} +: 8];
    w_half  = data_i[{r_lane[1], 4'b0000} +: 16];
    case (r_f3)
      F3_B:    w_ext = {{24{w_byte[7]}}, w_byte};
      F3_H:    w_ext = {{16{w_half[15]}}, w_half};
      F3_BU:   w_ext = {24'h0, w_byte};
      F3_HU:   w_ext = {16'h0, w_half};
      default: w_ext = data_i;
    endcase
    w_merge = data_i;
    if (r_f3[1:0] == 2'b00) begin
      w_merge[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
    end else begin
      w_merge[{r_lane[1], 4'b0000} +: 16] = r_wdata;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_f3    = r_f3;
    w_lane  = r_lane;
    w_store = r_store;
    w_wdata = r_wdata;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_fault = 1'b0;
    w_rd    = r_rd;
    w_we    = 1'b0;
    w_addr  = r_addr;
    w_data  = r_data;

    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        w_addr = 32'h0;
        w_data = 32'h0;
        if (start_i) begin
          if (!w_is_load && !w_is_store) begin
            w_done = 1'b1;
          end else if (!w_legal || w_misalign) begin
            w_done  = 1'b1;
            w_fault = 1'b1;
          end else begin
            w_f3    = funct3_i;
            w_lane  = addr_i[1:0];
            w_store = w_is_store;
            w_wdata = wdata_i[15:0];
            w_busy  = 1'b1;
            w_addr  = {addr_i[31:2], 2'b00};
            if (w_is_store && (funct3_i == F3_W)) begin
              w_data  = wdata_i;
              w_we    = 1'b1;
              w_state = ST_WRITE;
            end else begin
              w_cnt   = CNT_W'(RD_LAT - 1);
              w_state = ST_READ;
            end
          end
        end
      end

      ST_READ: begin
        if (r_cnt == '0) begin
          if (r_store) begin
            w_data  = w_merge;
            w_we    = 1'b1;
            w_state = ST_WRITE;
          end else begin
            w_rd    = w_ext;
            w_done  = 1'b1;
            w_busy  = 1'b0;
            w_addr  = 32'h0;
            w_data  = 32'h0;
            w_state = ST_IDLE;
          end
        end else begin
          w_cnt = r_cnt - CNT_W'(1);
        end
      end

      ST_WRITE: begin
        w_done  = 1'b1;
        w_busy  = 1'b0;
        w_addr  = 32'h0;
        w_data  = 32'h0;
        w_state = ST_IDLE;
      end

      default: begin
        w_busy  = 1'b0;
        w_addr  = 32'h0;
        w_data  = 32'h0;
        w_state = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any pending write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_f3    <= 3'h0;
      r_lane  <= 2'h0;
      r_store <= 1'b0;
      r_wdata <= 16'h0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_fault <= 1'b0;
      r_rd    <= 32'h0;
      r_we    <= 1'b0;
      r_addr  <= 32'h0;
      r_data  <= 32'h0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_f3    <= w_f3;
      r_lane  <= w_lane;
      r_store <= w_store;
      r_wdata <= w_wdata;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_fault <= w_fault;
      r_rd    <= w_rd;
      r_we    <= w_we;
      r_addr  <= w_addr;
      r_data  <= w_data;
    end
  end

  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign fault_o   = r_fault;
  assign rd_data_o = r_rd;
  assign we_o      = r_we;
  assign addr_o    = r_addr;
  assign data_o    = r_data;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: fixed vectors, corner sequences, and
// randomized accesses against a byte-lane arithmetic model of the RAM.
module tb_mem_access;

  localparam int RD_LAT = 2;
  localparam int MAXC   = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [1:0]  op_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        busy_o, done_o, fault_o, we_o;
  logic [31:0] rd_data_o, addr_o, data_i, data_o;

  mem_access #(.RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i), .funct3_i(funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o),
    .fault_o(fault_o), .rd_data_o(rd_data_o), .we_o(we_o), .addr_o(addr_o),
    .data_i(data_i), .data_o(data_o)
  );

  always #5 clk = ~clk;

  // RAM with a two-cycle read: address captured one edge after addr_o changes.
  logic [31:0] ram [256];
  logic [31:0] ram_addr_q;
  logic        poke_en;
  logic [7:0]  poke_idx;
  logic [31:0] poke_val;
  always @(posedge clk) begin
    ram_addr_q <= addr_o;
    if (poke_en) ram[poke_idx] <= poke_val;
    else if (we_o) ram[addr_o[9:2]] <= data_o;
  end
  assign data_i = ram[ram_addr_q[9:2]];

  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  logic [31:0] mm [256];
  logic [31:0] model_rd;

  task automatic poke(input logic [31:0] addr, input logic [31:0] val);
    poke_en = 1'b1; poke_idx = addr[9:2]; poke_val = val; mm[addr[9:2]] = val;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  int          obs_lat, obs_nwr;
  logic        obs_fault, obs_idle_ok;
  logic [31:0] obs_rd, obs_waddr, obs_wdata;

  task automatic access(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit glitch);
    start_i = 1'b1; op_i = op; funct3_i = f3; addr_i = addr; wdata_i = wdata;
    obs_lat = 0; obs_nwr = 0; obs_fault = 1'b0; obs_rd = 32'h0;
    obs_waddr = 32'h0; obs_wdata = 32'h0; obs_idle_ok = 1'b1;
    for (int c = 1; c <= MAXC; c++) begin
      @(negedge clk);
      if (we_o) begin obs_nwr++; obs_waddr = addr_o; obs_wdata = data_o; end
      if (c == 1 && glitch) begin
        start_i = 1'b1; op_i = 2'b10; funct3_i = 3'b010; addr_i = 32'h300; wdata_i = 32'hFFFFFFFF;
      end else begin
        start_i = 1'b0; op_i = 2'($urandom); funct3_i = 3'($urandom);
        addr_i = $urandom; wdata_i = $urandom;
      end
      if (done_o) begin
        obs_lat = c; obs_fault = fault_o; obs_rd = rd_data_o;
        if (we_o || busy_o || addr_o != 32'h0 || data_o != 32'h0) obs_idle_ok = 1'b0;
        break;
      end
      if (!busy_o) obs_idle_ok = 1'b0;
    end
    if (obs_lat == 0) $display("FAIL access timeout: no done_o within %0d cycles", MAXC);
  endtask

  int          e_lat;
  bit          e_flt, e_wr;
  logic [31:0] e_rd, e_word, e_waddr;

  // Reference: byte-lane arithmetic on the model memory.
  task automatic model(input logic [1:0] op, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    int nbytes, off;
    longint word, raw, mask;
    bit ld, st, legal, mis;
    ld = (op == 2'b01);
    st = (op == 2'b10);
    nbytes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off = (nbytes == 4) ? 0 : (int'(addr[1:0]) / nbytes) * nbytes;
    legal = ld ? (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
               : (f3 inside {3'b000, 3'b001, 3'b010});
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    mis = (int'(addr[1:0]) % nbytes) != 0;
`else
    mis = 1'b0;
`endif
    word = longint'(mm[addr[9:2]]);
    mask = (longint'(1) << (8 * nbytes)) - 1;
    e_flt = 1'b0; e_wr = 1'b0; e_lat = 1; e_rd = model_rd;
    e_word = mm[addr[9:2]]; e_waddr = {addr[31:2], 2'b00};
    if (!ld && !st) begin
      e_lat = 1;
    end else if (!legal || mis) begin
      e_flt = 1'b1;
    end else if (ld) begin
      raw = (word >> (8 * off)) & mask;
      if (!f3[2] && nbytes < 4 && raw >= (mask + 1) / 2) raw = raw - (mask + 1);
      e_rd = 32'(raw); model_rd = e_rd; e_lat = RD_LAT + 1;
    end else begin
      e_wr = 1'b1;
      e_word = 32'((word & ~(mask << (8 * off))) | ((longint'(wdata) & mask) << (8 * off)));
      mm[addr[9:2]] = e_word;
      e_lat = (nbytes == 4) ? 2 : RD_LAT + 2;
    end
  endtask

  task automatic verify(input string tag);
    check({tag, " latency"}, 32'(obs_lat), 32'(e_lat));
    check({tag, " fault"}, 32'(obs_fault), 32'(e_flt));
    check({tag, " rd_data"}, obs_rd, e_rd);
    check({tag, " writes"}, 32'(obs_nwr), e_wr ? 32'd1 : 32'd0);
    check({tag, " bus idle/busy"}, 32'(obs_idle_ok), 32'd1);
    if (e_wr) begin
      check({tag, " waddr"}, obs_waddr, e_waddr);
      check({tag, " wdata"}, obs_wdata, e_word);
    end
  endtask

  typedef struct {
    logic [31:0] pre;
    logic [1:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [31:0] exp_word;
    int          exp_lat;
    bit          exp_flt;
    bit          exp_wr;
  } vec_t;

  localparam int NV = 15;
  vec_t vt [NV];

  initial begin
    logic [1:0]  rop;
    logic [2:0]  rf3;
    logic [31:0] raddr, rwdata;
    bit          seen;

    vt[0]  = '{32'h8899AABB, 2'b01, 3'b000, 32'h101, 32'h0, 32'hFFFFFFAA, 32'h8899AABB, RD_LAT+1, 1'b0, 1'b0};
    vt[1]  = '{32'h8899AABB, 2'b01, 3'b100, 32'h101, 32'h0, 32'h000000AA, 32'h8899AABB, RD_LAT+1, 1'b0, 1'b0};
    vt[2]  = '{32'h8899AABB, 2'b01, 3'b001, 32'h102, 32'h0, 32'hFFFF8899, 32'h8899AABB, RD_LAT+1, 1'b0, 1'b0};
    vt[3]  = '{32'h8899AABB, 2'b01, 3'b101, 32'h100, 32'h0, 32'h0000AABB, 32'h8899AABB, RD_LAT+1, 1'b0, 1'b0};
    vt[4]  = '{32'h8899AABB, 2'b01, 3'b010, 32'h100, 32'h0, 32'h8899AABB, 32'h8899AABB, RD_LAT+1, 1'b0, 1'b0};
    vt[5]  = '{32'h11223344, 2'b10, 3'b001, 32'h102, 32'h0000CAFE, 32'h8899AABB, 32'hCAFE3344, RD_LAT+2, 1'b0, 1'b1};
    vt[6]  = '{32'h11223344, 2'b10, 3'b000, 32'h103, 32'h00000055, 32'h8899AABB, 32'h55223344, RD_LAT+2, 1'b0, 1'b1};
    vt[7]  = '{32'h00000000, 2'b10, 3'b010, 32'h200, 32'hDEADBEEF, 32'h8899AABB, 32'hDEADBEEF, 2, 1'b0, 1'b1};
    vt[8]  = '{32'h12345678, 2'b00, 3'b010, 32'h104, 32'hFFFFFFFF, 32'h8899AABB, 32'h12345678, 1, 1'b0, 1'b0};
    vt[9]  = '{32'h12345678, 2'b11, 3'b000, 32'h104, 32'hFFFFFFFF, 32'h8899AABB, 32'h12345678, 1, 1'b0, 1'b0};
    vt[10] = '{32'h12345678, 2'b01, 3'b011, 32'h104, 32'h0, 32'h8899AABB, 32'h12345678, 1, 1'b1, 1'b0};
    vt[11] = '{32'h12345678, 2'b10, 3'b100, 32'h104, 32'hFFFFFFFF, 32'h8899AABB, 32'h12345678, 1, 1'b1, 1'b0};
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    vt[12] = '{32'hCAFEF00D, 2'b01, 3'b010, 32'h102, 32'h0, 32'h8899AABB, 32'hCAFEF00D, 1, 1'b1, 1'b0};
    vt[13] = '{32'hCAFEF00D, 2'b01, 3'b001, 32'h103, 32'h0, 32'h8899AABB, 32'hCAFEF00D, 1, 1'b1, 1'b0};
    vt[14] = '{32'h11223344, 2'b10, 3'b001, 32'h101, 32'h0000BEEF, 32'h8899AABB, 32'h11223344, 1, 1'b1, 1'b0};
`else
    vt[12] = '{32'hCAFEF00D, 2'b01, 3'b010, 32'h102, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D, RD_LAT+1, 1'b0, 1'b0};
    vt[13] = '{32'hCAFEF00D, 2'b01, 3'b001, 32'h103, 32'h0, 32'hFFFFCAFE, 32'hCAFEF00D, RD_LAT+1, 1'b0, 1'b0};
    vt[14] = '{32'h11223344, 2'b10, 3'b001, 32'h101, 32'h0000BEEF, 32'hFFFFCAFE, 32'h1122BEEF, RD_LAT+2, 1'b0, 1'b1};
`endif

    reset = 1'b1; start_i = 1'b0; op_i = 2'b00; funct3_i = 3'b000;
    addr_i = 32'h0; wdata_i = 32'h0; poke_en = 1'b0; poke_idx = 8'h0; poke_val = 32'h0;
    repeat (3) @(negedge clk);
    check("reset busy_o", 32'(busy_o), 32'd0);
    check("reset done_o", 32'(done_o), 32'd0);
    check("reset fault_o", 32'(fault_o), 32'd0);
    check("reset we_o", 32'(we_o), 32'd0);
    check("reset rd_data_o", rd_data_o, 32'h0);
    check("reset addr_o", addr_o, 32'h0);
    check("reset data_o", data_o, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      poke(vt[i].addr, vt[i].pre);
      access(vt[i].op, vt[i].f3, vt[i].addr, vt[i].wdata, 1'b0);
      check($sformatf("vec%0d latency", i), 32'(obs_lat), 32'(vt[i].exp_lat));
      check($sformatf("vec%0d fault", i), 32'(obs_fault), 32'(vt[i].exp_flt));
      check($sformatf("vec%0d rd_data", i), obs_rd, vt[i].exp_rd);
      check($sformatf("vec%0d writes", i), 32'(obs_nwr), vt[i].exp_wr ? 32'd1 : 32'd0);
      check($sformatf("vec%0d ram word", i), ram[vt[i].addr[9:2]], vt[i].exp_word);
      check($sformatf("vec%0d bus idle/busy", i), 32'(obs_idle_ok), 32'd1);
      if (vt[i].exp_wr) check($sformatf("vec%0d waddr", i), obs_waddr, {vt[i].addr[31:2], 2'b00});
      @(negedge clk);
      check($sformatf("vec%0d quiet after done", i), 32'({done_o, busy_o, we_o}), 32'd0);
    end

    // SW with a second start pulsed while busy: only one write may happen.
    poke(32'h300, 32'h13579BDF);
    poke(32'h200, 32'h0);
    access(2'b10, 3'b010, 32'h200, 32'hDEADBEEF, 1'b1);
    check("sw busy latency", 32'(obs_lat), 32'd2);
    check("sw busy writes", 32'(obs_nwr), 32'd1);
    check("sw busy waddr", obs_waddr, 32'h200);
    check("sw busy ram 0x200", ram[8'h80], 32'hDEADBEEF);
    check("sw busy ram 0x300", ram[8'hC0], 32'h13579BDF);
    seen = 1'b0;
    repeat (4) begin @(negedge clk); if (done_o || we_o || busy_o) seen = 1'b1; end
    check("sw busy no extra access", 32'(seen), 32'd0);

    // Back-to-back: second start issued in the done_o cycle of the first.
    poke(32'h140, 32'h80FF017F);
    access(2'b01, 3'b000, 32'h140, 32'h0, 1'b0);
    check("b2b first latency", 32'(obs_lat), 32'(RD_LAT + 1));
    check("b2b first rd", obs_rd, 32'h0000007F);
    access(2'b01, 3'b100, 32'h143, 32'h0, 1'b0);
    check("b2b second latency", 32'(obs_lat), 32'(RD_LAT + 1));
    check("b2b second rd", obs_rd, 32'h00000080);

    // Reset asserted during the write cycle of an SB.
    poke(32'h104, 32'h11223344);
    start_i = 1'b1; op_i = 2'b10; funct3_i = 3'b000; addr_i = 32'h104; wdata_i = 32'h99;
    @(negedge clk);
    start_i = 1'b0;
    seen = 1'b0;
    for (int c = 1; c <= MAXC; c++) begin
      if (we_o) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check("sb reset reached write", 32'(seen), 32'd1);
    check("sb reset merged data", data_o, 32'h11223399);
    reset = 1'b1;
    @(negedge clk);
    check("sb reset we_o", 32'(we_o), 32'd0);
    check("sb reset done_o", 32'(done_o), 32'd0);
    check("sb reset outputs", 32'({busy_o, fault_o}) | addr_o | data_o | rd_data_o, 32'h0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (4) begin @(negedge clk); if (done_o || we_o || busy_o) seen = 1'b1; end
    check("sb reset quiet after", 32'(seen), 32'd0);

    // Randomized accesses against the reference model.
    for (int i = 0; i < 256; i++) poke(32'(i * 4), $urandom);
    model_rd = 32'h0;
    for (int n = 0; n < 300; n++) begin
      rop = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(1, 2));
      rf3 = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7))
                                        : 3'($urandom_range(0, 2)) | ($urandom_range(0, 1) ? 3'b100 : 3'b000);
      raddr  = 32'($urandom_range(0, 1023));
      rwdata = $urandom;
      model(rop, rf3, raddr, rwdata);
      access(rop, rf3, raddr, rwdata, 1'b0);
      verify($sformatf("rnd%0d", n));
      if (e_wr) check($sformatf("rnd%0d ram", n), ram[raddr[9:2]], e_word);
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        check($sformatf("rnd%0d quiet", n), 32'({done_o, busy_o, we_o}), 32'd0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
